// File: rtl/entrada_pkg.sv
// Shared types and constants for the entrada_handshake IN stage.
// The optional echo port is controlled by the ENTRADA_ECO_EN macro in entrada_handshake.
package entrada_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ESPERA_PRESS,
    ESPERA_SOLTA,
    LIBERA,
    GUARDA
  } estado_t;

  // Cycles spent ignoring in_req after release, covering synchronizer latency.
  localparam int GUARDA_CYCLES = 3;
  localparam int SYNC_DEPTH    = 2;

endpackage

// File: rtl/debounce_botao.sv
// Synchronizer and debouncer for the active-low confirm button.
// Produces one-cycle pulses on debounced press (1->0) and release (0->1) transitions.
module debounce_botao
  import entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
)
(
  input  logic clock_fpga,
  input  logic reset,
  input  logic botao_i,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_s;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  nivel_q, nivel_d;
  logic                  press_q, press_d;
  logic                  release_q, release_d;

  assign sync_s = sync_q[SYNC_DEPTH-1];

  // Counter runs only while the synchronized input disagrees with the
  // debounced level; any return to agreement restarts it from zero.
  always_comb begin
    cnt_d     = cnt_q;
    nivel_d   = nivel_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_s == nivel_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX) begin
        nivel_d   = sync_s;
        press_d   = ~sync_s;
        release_d = sync_s;
      end
    end
  end

  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      nivel_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_DEPTH-2:0], botao_i};
      cnt_q     <= cnt_d;
      nivel_q   <= nivel_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/entrada_handshake.sv
// Interactive IN stage: freezes the processor, waits for a confirmed switch value, releases one instruction.
// Defining ENTRADA_ECO_EN adds the 'eco' port showing live/latched switches.
module entrada_handshake
  import entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_WIDTH        = 8,
  parameter int IMM_WIDTH       = 14
)
(
  input  logic                 clock_fpga,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  switches,
  input  logic                 botao,
  input  logic                 in_req,
  input  logic                 avanca,
  output logic                 congela,
  output logic [IMM_WIDTH-1:0] entrada_switch,
`ifdef ENTRADA_ECO_EN
  output logic                 in_valido,
  output logic [SW_WIDTH-1:0]  eco
`else
  output logic                 in_valido
`endif
);

  localparam int GW = $clog2(GUARDA_CYCLES);

  logic [SYNC_DEPTH-1:0]  req_sync_q;
  logic                   req_s;
  logic                   press_s, release_s;
  estado_t                state_q, state_d;
  logic [GW-1:0]          guarda_q, guarda_d;
  logic [IMM_WIDTH-1:0]   entrada_q, entrada_d;
  logic                   valido_q, valido_d;

  assign req_s = req_sync_q[SYNC_DEPTH-1];

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock_fpga(clock_fpga),
    .reset     (reset),
    .botao_i   (botao),
    .press_o   (press_s),
    .release_o (release_s)
  );

  // congela is decoded from the state register so reset clears it asynchronously.
  always_comb begin
    state_d   = state_q;
    guarda_d  = guarda_q;
    entrada_d = entrada_q;
    valido_d  = 1'b0;
    congela   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) state_d = ESPERA_PRESS;
      end
      ESPERA_PRESS: begin
        congela = 1'b1;
        if (press_s) begin
          entrada_d = IMM_WIDTH'(switches);
          valido_d  = 1'b1;
          state_d   = ESPERA_SOLTA;
        end
      end
      ESPERA_SOLTA: begin
        congela = 1'b1;
        if (release_s) state_d = LIBERA;
      end
      LIBERA: begin
        if (avanca) begin
          guarda_d = '0;
          state_d  = GUARDA;
        end
      end
      GUARDA: begin
        if (guarda_q == GW'(GUARDA_CYCLES - 1)) state_d = IDLE;
        else guarda_d = guarda_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      req_sync_q <= '0;
      state_q    <= IDLE;
      guarda_q   <= '0;
      entrada_q  <= '0;
      valido_q   <= 1'b0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_DEPTH-2:0], in_req};
      state_q    <= state_d;
      guarda_q   <= guarda_d;
      entrada_q  <= entrada_d;
      valido_q   <= valido_d;
    end
  end

  assign entrada_switch = entrada_q;
  assign in_valido      = valido_q;

`ifdef ENTRADA_ECO_EN
  logic [SW_WIDTH-1:0] eco_q;

  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) eco_q <= '0;
    else if (state_q == ESPERA_PRESS) eco_q <= switches;
    else eco_q <= entrada_q[SW_WIDTH-1:0];
  end

  assign eco = eco_q;
`endif

endmodule

// File: tb/tb_entrada_handshake.sv
// Self-checking bench for entrada_handshake with DEBOUNCE_CYCLES=4, randomized switch values and bounce.
// Expectations come from the documented latencies and a latched-value/pulse-count reference.
module tb_entrada_handshake;

  localparam int D   = 4;
  localparam int SW  = 8;
  localparam int IMM = 14;

  // Documented latencies, in clock_fpga cycles.
  localparam int LAT_REQ    = 3;          // 2 sync + 1 FSM
  localparam int LAT_PRESS  = 2 + D + 1;  // sync + debounce + latch
  localparam int LAT_SOLTA  = 2 + D + 1;  // sync + debounce + state change
  localparam int LAT_REARME = 3 + 1;      // GUARDA cycles + one IDLE cycle

  logic           clock_fpga = 1'b0;
  logic           reset;
  logic [SW-1:0]  switches;
  logic           botao;
  logic           in_req;
  logic           avanca;
  logic           congela;
  logic [IMM-1:0] entrada_switch;
  logic           in_valido;
`ifdef ENTRADA_ECO_EN
  logic [SW-1:0]  eco;
`endif

  int errors = 0;
  int checks = 0;
  int pulseCount = 0;
  logic [IMM-1:0] expLatched = '0;

  entrada_handshake #(
    .DEBOUNCE_CYCLES(D),
    .SW_WIDTH       (SW),
    .IMM_WIDTH      (IMM)
  ) dut (
    .clock_fpga    (clock_fpga),
    .reset         (reset),
    .switches      (switches),
    .botao         (botao),
    .in_req        (in_req),
    .avanca        (avanca),
    .congela       (congela),
    .entrada_switch(entrada_switch),
`ifdef ENTRADA_ECO_EN
    .in_valido     (in_valido),
    .eco           (eco)
`else
    .in_valido     (in_valido)
`endif
  );

  always #5 clock_fpga = ~clock_fpga;

  // Counts in_valido pulses just after each edge so readers at negedge never race it.
  always @(posedge clock_fpga) begin
    #1;
    if (in_valido === 1'b1) pulseCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock_fpga);
  endtask

  task automatic waitCongela(input logic level, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock_fpga);
      cyc++;
    end while (congela !== level && cyc < 30);
  endtask

  task automatic waitValid(output int cyc, output logic [IMM-1:0] val);
    cyc = 0;
    do begin
      @(negedge clock_fpga);
      cyc++;
    end while (in_valido !== 1'b1 && cyc < 30);
    val = entrada_switch;
  endtask

  task automatic pulseAvanca();
    avanca = 1'b1;
    tick(1);
    avanca = 1'b0;
  endtask

  // One IN instruction, entered in ESPERA_PRESS with the button released.
  task automatic applyStimulus(input logic [SW-1:0] sw, input int glitches, input int holdExtra);
    int p0, cyc;
    logic [IMM-1:0] val;
    p0 = pulseCount;
`ifdef ENTRADA_ECO_EN
    switches = 8'h11;
    tick(1);
    checkOutput("eco_live_11", eco, 8'h11);
    switches = 8'h22;
    tick(1);
    checkOutput("eco_live_22", eco, 8'h22);
`endif
    switches = sw;
    for (int g = 0; g < glitches; g++) begin
      botao = 1'b0;
      tick($urandom_range(1, D - 1));
      botao = 1'b1;
      tick($urandom_range(1, 3));
    end
    pulseAvanca();
    tick(1);
    checkOutput("no_latch_bounce", pulseCount - p0, 0);
    checkOutput("congela_waiting", congela, 1'b1);
    botao = 1'b0;
    waitValid(cyc, val);
    expLatched = IMM'(sw);
    checkOutput("press_latency", cyc, LAT_PRESS);
    checkOutput("latched_value", val, expLatched);
`ifdef ENTRADA_ECO_EN
    switches = ~sw;
    tick(1);
    checkOutput("eco_holds", eco, sw);
    switches = sw;
`endif
    tick(holdExtra);
    checkOutput("congela_held", congela, 1'b1);
    botao = 1'b1;
    waitCongela(1'b0, cyc);
    checkOutput("release_latency", cyc, LAT_SOLTA);
    checkOutput("single_pulse", pulseCount - p0, 1);
    checkOutput("value_kept", entrada_switch, expLatched);
  endtask

  // From LIBERA with in_req high: optional ignored press, then release the instruction.
  task automatic nextInstruction();
    int p0, cyc;
    p0 = pulseCount;
    if ($urandom_range(0, 1) == 1) begin
      switches = 8'($urandom);
      botao = 1'b0;
      tick(8);
      botao = 1'b1;
      tick(8);
      checkOutput("libera_press_ignored", pulseCount - p0, 0);
      checkOutput("libera_congela_low", congela, 1'b0);
    end
    pulseAvanca();
    waitCongela(1'b1, cyc);
    checkOutput("rearm_latency", cyc, LAT_REARME);
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : main
    int cyc, p0;
    logic [IMM-1:0] val;
    logic [SW-1:0] sw2;

    reset    = 1'b1;
    switches = '0;
    botao    = 1'b1;
    in_req   = 1'b0;
    avanca   = 1'b0;
    tick(3);
    checkOutput("reset_congela", congela, 1'b0);
    checkOutput("reset_entrada", entrada_switch, 0);
    checkOutput("reset_valido", in_valido, 1'b0);
    reset = 1'b0;
    tick(3);
    checkOutput("idle_congela", congela, 1'b0);

    in_req = 1'b1;
    waitCongela(1'b1, cyc);
    checkOutput("req_latency", cyc, LAT_REQ);
    applyStimulus(8'hA5, 0, 3);

    nextInstruction();
    applyStimulus(8'h03, 3, 1);
    nextInstruction();
    applyStimulus(8'hFF, 0, 2);
    for (int i = 0; i < 4; i++) begin
      nextInstruction();
      applyStimulus(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 5));
    end

    // Button already held when the instruction arrives.
    in_req = 1'b0;
    pulseAvanca();
    tick(10);
    checkOutput("idle_after_guard", congela, 1'b0);
    p0 = pulseCount;
    switches = 8'h5A;
    botao = 1'b0;
    tick(10);
    in_req = 1'b1;
    waitCongela(1'b1, cyc);
    checkOutput("held_req_latency", cyc, LAT_REQ);
    tick(10);
    checkOutput("held_no_latch", pulseCount - p0, 0);
    checkOutput("held_value_old", entrada_switch, expLatched);
    botao = 1'b1;
    tick(10);
    sw2 = 8'($urandom);
    applyStimulus(sw2, 0, 2);

    // Reset while waiting for release.
    pulseAvanca();
    waitCongela(1'b1, cyc);
    checkOutput("rearm_before_reset", cyc, LAT_REARME);
    switches = 8'($urandom);
    botao = 1'b0;
    waitValid(cyc, val);
    checkOutput("pre_reset_latch", val, IMM'(switches));
    p0 = pulseCount;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_congela", congela, 1'b0);
    checkOutput("async_entrada", entrada_switch, 0);
    checkOutput("async_valido", in_valido, 1'b0);
    in_req = 1'b0;
    botao  = 1'b1;
    @(negedge clock_fpga);
    reset = 1'b0;
    tick(15);
    checkOutput("post_reset_pulses", pulseCount - p0, 0);
    checkOutput("post_reset_congela", congela, 1'b0);
    checkOutput("post_reset_entrada", entrada_switch, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/entrada_handshake.md
# entrada_handshake

Interactive input stage between the FPGA board and the processor's IN path. When the control unit flags an IN instruction, the block freezes the processor clock divider and waits for the operator to set the switches and press a confirm button. It then latches the switch value, zero-extended to the immediate width, and releases the processor for exactly one instruction.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: cycles the synchronized button must be stable before its debounced level changes (10 ms at 50 MHz).
- SW_WIDTH, 8: switch count.
- IMM_WIDTH, 14: width of the value handed to the IN mux.

Ports:
- clock_fpga  in  1  board clock; every flop in the block is on it.
- reset  in  1  asynchronous, active-high.
- switches  in  SW_WIDTH  raw board switches.
- botao  in  1  raw confirm pushbutton, active-low (0 = pressed).
- in_req  in  1  control-unit `in` flag; level, processor-clock domain.
- avanca  in  1  one-cycle pulse from the clock divider at each processor clock rising edge.
- congela  out  1  freeze request to the clock divider.
- entrada_switch  out  IMM_WIDTH  latched value, {zeros, switches}.
- in_valido  out  1  one-cycle pulse when a new value is latched.

## Operation
- in_req passes through a 2-flop synchronizer. botao passes through a 2-flop synchronizer and then the debouncer.
- FSM states:
  - IDLE: congela=0. If synchronized in_req=1, go to ESPERA_PRESS.
  - ESPERA_PRESS: congela=1. On a debounced press edge, set entrada_switch={(IMM_WIDTH-SW_WIDTH)'0, switches}, pulse in_valido, and go to ESPERA_SOLTA.
  - ESPERA_SOLTA: congela=1. On a debounced release edge, go to LIBERA.
  - LIBERA: congela=0. On avanca=1, go to GUARDA.
  - GUARDA: congela=0. Wait 3 cycles, ignoring in_req, then go to IDLE. This covers synchronizer latency after the instruction change.
- Back-to-back IN instructions: in_req stays high. Re-entry through GUARDA → IDLE → ESPERA_PRESS makes each instruction demand its own press.
- A button already held when ESPERA_PRESS is entered does not count. Only a release→press edge observed while in ESPERA_PRESS latches a value.
- Presses in IDLE, LIBERA and GUARDA are ignored. The debouncer keeps tracking the button in every state.
- entrada_switch holds its value until the next latch. It is never cleared except by reset.

## Timing
- Reset values: state IDLE, congela 0, entrada_switch 0, in_valido 0, debounced button = released, synchronizers 1 for botao and 0 for in_req.
- Reset asserted mid-wait: congela drops asynchronously. No value is latched.
- in_req rise → congela high: 3 clock_fpga cycles (2 synchronizer + 1 FSM).
- Stable botao=0 → in_valido pulse: 2 + DEBOUNCE_CYCLES + 1 cycles. entrada_switch is updated on the same edge as the in_valido pulse.
- Debounce counter: resets on any change of the synchronized input. It saturates at DEBOUNCE_CYCLES, and the debounced level toggles on the cycle it is reached.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). Glitches shorter than DEBOUNCE_CYCLES never reach the FSM.
- The switches are sampled raw on the latch cycle. The operator sets them before pressing.
- avanca outside LIBERA is ignored.

## Configuration
- ENTRADA_ECO_EN defined: an extra output port `eco` (SW_WIDTH) is added.
  - In ESPERA_PRESS it shows the live switches, registered with 1 cycle latency.
  - Otherwise it shows entrada_switch[SW_WIDTH-1:0].
  - Reset value is 0.
- Undefined: the port and its register do not exist. All other behaviour is identical.

## Structure
- Package entrada_pkg holds:
  - the FSM state enum (IDLE, ESPERA_PRESS, ESPERA_SOLTA, LIBERA, GUARDA);
  - the GUARDA_CYCLES=3 constant;
  - the synchronizer depth constant 2.
- Sub-module debounce_botao holds the synchronizer, counter, debounced level, and one-cycle press/release edge outputs. It is instantiated once.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SW_WIDTH=8.
- Reset, then in_req=1 and switches=8'hA5, botao pressed for 10 cycles then released → congela high 3 cycles after in_req; entrada_switch=14'h00A5 with a single in_valido pulse; congela low after release; state LIBERA.
- Button bounce of 0/1 alternating every 2 cycles for 12 cycles, then low → no latch during the bounce; exactly one in_valido, 7 cycles after the stable low starts.
- Two consecutive IN instructions, with in_req held high and avanca pulsed once between them, using switches 8'h03 then 8'hFF → two separate presses required; values 14'h0003 then 14'h00FF.
- Button already held when in_req rises → no latch until release then press; the value is switches at the second press.
- reset asserted in ESPERA_SOLTA → congela=0 immediately, entrada_switch=0, state IDLE; no in_valido.
- ENTRADA_ECO_EN build: switches toggled 8'h11→8'h22 during ESPERA_PRESS → eco follows with 1 cycle lag; after the latch, eco holds the latched value while switches change.
